// File: rtl/pipe_adder_nbit.sv
// pipe_adder_nbit: pipelined ripple-carry adder, STAGE_W bits per stage.
// Each stage register holds a valid bit, the sum bits completed so far, the
// slice carry, and the operands (whose upper slices are still unprocessed).
// Stages advance independently, so bubbles collapse under a downstream stall.
// Optional build macro: PIPE_ADD_SAT_EN (unsigned saturation of sum on carry out).
module pipe_adder_nbit #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / STAGE_W;

    // stage registers
    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0][WIDTH-1:0] sum_r;
    logic [STAGES-1:0][WIDTH-1:0] opa_r;
    logic [STAGES-1:0][WIDTH-1:0] opb_r;
    logic [STAGES-1:0]            cy_r;
    logic                         ovf_r;

    // per-stage next-state values
    logic [STAGES-1:0]              ld;
    logic [STAGES-1:0]              src_v;
    logic [STAGES-1:0]              src_c;
    logic [STAGES-1:0][WIDTH-1:0]   src_a;
    logic [STAGES-1:0][WIDTH-1:0]   src_b;
    logic [STAGES-1:0][WIDTH-1:0]   nxt_sum;
    logic [STAGES-1:0][STAGE_W:0]   slc;
    logic                           nxt_ovf;

    // load enables: a stage loads when empty or when the stage after it takes its entry
    always_comb begin
        ld = '0;
        ld[STAGES-1] = !vld[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--)
            ld[k] = !vld[k] || ld[k+1];
    end

    // slice adders: stage 0 takes the ports, later stages take the previous register
    always_comb begin
        src_v   = '0;
        src_c   = '0;
        src_a   = '0;
        src_b   = '0;
        nxt_sum = '0;
        slc     = '0;
        nxt_ovf = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_v[k]   = in_valid;
                src_c[k]   = cin;
                src_a[k]   = a;
                src_b[k]   = b;
                nxt_sum[k] = '0;
            end else begin
                src_v[k]   = vld[k-1];
                src_c[k]   = cy_r[k-1];
                src_a[k]   = opa_r[k-1];
                src_b[k]   = opb_r[k-1];
                nxt_sum[k] = sum_r[k-1];
            end
            slc[k] = {1'b0, src_a[k][k*STAGE_W +: STAGE_W]}
                   + {1'b0, src_b[k][k*STAGE_W +: STAGE_W]}
                   + {{STAGE_W{1'b0}}, src_c[k]};
            nxt_sum[k][k*STAGE_W +: STAGE_W] = slc[k][STAGE_W-1:0];
        end
        // carry into the MSB is recovered from the MSB operand bits and result bit
        nxt_ovf = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
                ^ slc[STAGES-1][STAGE_W-1] ^ slc[STAGES-1][STAGE_W];
`ifdef PIPE_ADD_SAT_EN
        if (slc[STAGES-1][STAGE_W])
            nxt_sum[STAGES-1] = '1;
`else
`endif
    end

    // stage registers advance on their own load enable; reset drops all in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= '0;
            sum_r <= '0;
            cy_r  <= '0;
            ovf_r <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld[k]   <= src_v[k];
                    sum_r[k] <= nxt_sum[k];
                    cy_r[k]  <= slc[k][STAGE_W];
                    opa_r[k] <= src_a[k];
                    opb_r[k] <= src_b[k];
                end
            end
            if (ld[STAGES-1])
                ovf_r <= nxt_ovf;
        end
    end

    // outputs come straight from the last stage, forced quiet while reset is held
    always_comb begin
        in_ready  = !rst && ld[0];
        out_valid = !rst && vld[STAGES-1];
        sum       = rst ? '0 : sum_r[STAGES-1];
        cout      = !rst && cy_r[STAGES-1];
        ovf       = !rst && ovf_r;
    end
endmodule
